// File: rtl/cpu_pkg.sv
// Shared definitions for the PC sequencer: one-hot phase encoding and defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

  localparam int          WIDTH_DEF    = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // One-hot instruction phase, bit order {WB,MEM,EX,ID,IF}.
  typedef enum logic [4:0] {
    PH_IF  = 5'b00001,
    PH_ID  = 5'b00010,
    PH_EX  = 5'b00100,
    PH_MEM = 5'b01000,
    PH_WB  = 5'b10000
  } phase_e;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: pc+4, branch, jump or jump-register, jr having highest priority.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
// Ports: pc, decode flags (is_branch/branch_taken/is_jump/is_jr), imm, jtarget,
//        rs_val in; target out.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             is_branch,
  input  logic             branch_taken,
  input  logic             is_jump,
  input  logic             is_jr,
  input  logic [15:0]      imm,
  input  logic [25:0]      jtarget,
  input  logic [WIDTH-1:0] rs_val,
  output logic [WIDTH-1:0] target
);

  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] br_off;

  // Both sums wrap naturally at 2^WIDTH.
  assign pc4    = pc + WIDTH'(4);
  assign br_off = {{(WIDTH-18){imm[15]}}, imm, 2'b00};

  always_comb begin
    target = pc4;
    if (is_jr) begin
      target = {rs_val[WIDTH-1:2], 2'b00};
    end else if (is_jump) begin
      target = {pc4[WIDTH-1:28], jtarget, 2'b00};
    end else if (is_branch && branch_taken) begin
      target = pc4 + br_off;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Five-phase instruction sequencer (IF,ID,EX,MEM,WB) driving the PC register.
// Latency: 5 cycles per instruction plus IF/MEM wait cycles; next_pc captured at EX->MEM.
// Backpressure: mem_ready low stalls in IF and MEM; ignored in other phases.
// Ports: clk, rst (async active-low), pc, mem_ready, decode inputs in;
//        phase, ir_we, pc_we, next_pc, retired out.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF,
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  input  logic             mem_ready,
  input  logic             is_branch,
  input  logic             branch_taken,
  input  logic             is_jump,
  input  logic             is_jr,
  input  logic [15:0]      imm,
  input  logic [25:0]      jtarget,
  input  logic [WIDTH-1:0] rs_val,
  output logic [4:0]       phase,
  output logic             ir_we,
  output logic             pc_we,
  output logic [WIDTH-1:0] next_pc,
  output logic [CNT_W-1:0] retired
);

  phase_e           state_q, state_d;
  logic [WIDTH-1:0] target;

  next_pc_calc #(.WIDTH(WIDTH)) u_calc (
    .pc           (pc),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .is_jump      (is_jump),
    .is_jr        (is_jr),
    .imm          (imm),
    .jtarget      (jtarget),
    .rs_val       (rs_val),
    .target       (target)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PH_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    unique case (state_q)
      PH_IF: begin
        // Strobe is masked while reset is held so no IR load escapes during reset.
        ir_we = mem_ready & rst;
        if (mem_ready) state_d = PH_ID;
      end
      PH_ID:  state_d = PH_EX;
      PH_EX:  state_d = PH_MEM;
      PH_MEM: if (mem_ready) state_d = PH_WB;
      PH_WB: begin
        pc_we   = 1'b1;
        state_d = PH_IF;
      end
      default: state_d = PH_IF;
    endcase
  end

  assign phase = state_q;

  // Decode inputs are only observed on the EX->MEM edge; next_pc holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_pc <= RESET_PC;
    end else if (state_q == PH_EX) begin
      next_pc <= target;
    end
  end

  // One retirement per WB->IF edge; wraps at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired <= '0;
    end else if (state_q == PH_WB) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        mem_ready = 1'b0;
  logic        is_branch = 1'b0;
  logic        branch_taken = 1'b0;
  logic        is_jump = 1'b0;
  logic        is_jr = 1'b0;
  logic [15:0] imm = '0;
  logic [25:0] jtarget = '0;
  logic [31:0] rs_val = '0;

  logic [4:0]  phase, phase_s;
  logic        ir_we, ir_we_s, pc_we, pc_we_s;
  logic [31:0] next_pc, next_pc_s;
  logic [31:0] retired;
  logic [2:0]  retired_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .pc(pc), .mem_ready(mem_ready),
    .is_branch(is_branch), .branch_taken(branch_taken), .is_jump(is_jump),
    .is_jr(is_jr), .imm(imm), .jtarget(jtarget), .rs_val(rs_val),
    .phase(phase), .ir_we(ir_we), .pc_we(pc_we), .next_pc(next_pc),
    .retired(retired)
  );

  // Narrow counter instance so counter wrap is reachable in a short run.
  pc_sequencer #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .pc(pc), .mem_ready(mem_ready),
    .is_branch(is_branch), .branch_taken(branch_taken), .is_jump(is_jump),
    .is_jr(is_jr), .imm(imm), .jtarget(jtarget), .rs_val(rs_val),
    .phase(phase_s), .ir_we(ir_we_s), .pc_we(pc_we_s), .next_pc(next_pc_s),
    .retired(retired_s)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference next-PC computed with plain arithmetic from the rules.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic br, input logic tk,
                                           input logic j, input logic jr, input logic [15:0] im,
                                           input logic [25:0] jt, input logic [31:0] rs);
    logic [31:0] p4;
    int off;
    p4  = p + 32'd4;
    off = int'($signed(im)) * 4;
    if (jr)            return rs & 32'hFFFF_FFFC;
    else if (j)        return (p4 & 32'hF000_0000) | (32'(jt) << 2);
    else if (br && tk) return p4 + 32'(off);
    else               return p4;
  endfunction

  // Model: phase index 0..4 = IF..WB, latched target, retired count.
  int          m_ph  = 0;
  logic [31:0] m_npc = 32'h0;
  longint      m_ret = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph = 0; m_npc = 32'h0; m_ret = 0;
    end else begin
      case (m_ph)
        0: if (mem_ready) m_ph = 1;
        1: m_ph = 2;
        2: begin
             m_npc = ref_next(pc, is_branch, branch_taken, is_jump, is_jr, imm, jtarget, rs_val);
             m_ph  = 3;
           end
        3: if (mem_ready) m_ph = 4;
        default: begin m_ph = 0; m_ret = m_ret + 1; end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [63:0] r;
    r = 64'(m_ret);
    check("phase",     64'(phase),    64'(5'b1 << m_ph));
    check("ir_we",     64'(ir_we),    64'(rst && m_ph == 0 && mem_ready));
    check("pc_we",     64'(pc_we),    64'(m_ph == 4));
    check("next_pc",   64'(next_pc),  64'(m_npc));
    check("retired",   64'(retired),  64'(r[31:0]));
    check("phase_s",   64'(phase_s),  64'(5'b1 << m_ph));
    check("ir_we_s",   64'(ir_we_s),  64'(rst && m_ph == 0 && mem_ready));
    check("pc_we_s",   64'(pc_we_s),  64'(m_ph == 4));
    check("next_pc_s", 64'(next_pc_s), 64'(m_npc));
    check("retired_s", 64'(retired_s), 64'(r[2:0]));
  end

  int cyc, irc, pcc, ir_at, pc_at;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (ir_we) begin irc++; ir_at = cyc; end
    if (pc_we) begin pcc++; pc_at = cyc; end
    @(posedge clk);
    #2;
  endtask

  task automatic rand_decode();
    pc           = $urandom;
    rs_val       = $urandom;
    imm          = 16'($urandom);
    jtarget      = 26'($urandom);
    is_branch    = 1'($urandom_range(0, 1));
    branch_taken = 1'($urandom_range(0, 1));
    is_jump      = 1'($urandom_range(0, 1));
    is_jr        = 1'($urandom_range(0, 1));
  endtask

  // Runs one instruction from IF; decode values are presented only in EX.
  task automatic run_instr(input logic [31:0] p, input logic br, input logic tk, input logic j,
                           input logic jr, input logic [15:0] im, input logic [25:0] jt,
                           input logic [31:0] rs, input int ifw, input int memw);
    cyc = 0; irc = 0; pcc = 0; ir_at = 0; pc_at = 0;
    repeat (ifw) begin rand_decode(); mem_ready = 1'b0; step(); end
    rand_decode(); mem_ready = 1'b1; step();
    rand_decode(); mem_ready = 1'($urandom_range(0, 1)); step();
    pc = p; is_branch = br; branch_taken = tk; is_jump = j; is_jr = jr;
    imm = im; jtarget = jt; rs_val = rs; mem_ready = 1'($urandom_range(0, 1));
    step();
    repeat (memw) begin rand_decode(); mem_ready = 1'b0; step(); end
    rand_decode(); mem_ready = 1'b1; step();
    rand_decode(); mem_ready = 1'($urandom_range(0, 1)); step();
  endtask

  initial begin
    #1 rst = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_phase",   64'(phase),   64'h1);
    check("rst_next_pc", 64'(next_pc), 64'h0);
    check("rst_retired", 64'(retired), 64'h0);
    check("rst_pc_we",   64'(pc_we),   64'h0);
    check("rst_ir_we",   64'(ir_we),   64'h0);
    rst = 1'b1;

    // Sequential instruction timing.
    run_instr(32'h100, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
    check("seq_next_pc", 64'(next_pc), 64'h104);
    check("seq_cycles",  64'(cyc),  64'd5);
    check("seq_ir_cnt",  64'(irc),  64'd1);
    check("seq_ir_at",   64'(ir_at), 64'd1);
    check("seq_pc_cnt",  64'(pcc),  64'd1);
    check("seq_pc_at",   64'(pc_at), 64'd5);
    check("seq_retired", 64'(retired), 64'd1);

    run_instr(32'h100, 1, 1, 0, 0, 16'hFFFE, 26'h0, 32'h0, 0, 0);
    check("br_taken", 64'(next_pc), 64'hFC);
    run_instr(32'h100, 1, 0, 0, 0, 16'hFFFE, 26'h0, 32'h0, 0, 0);
    check("br_not_taken", 64'(next_pc), 64'h104);
    run_instr(32'h8000_0000, 0, 0, 1, 1, 16'h0, 26'h10, 32'h1237, 0, 0);
    check("jr_wins", 64'(next_pc), 64'h1234);
    run_instr(32'h8000_0000, 1, 1, 1, 0, 16'h7, 26'h10, 32'h1237, 0, 0);
    check("jump", 64'(next_pc), 64'h8000_0040);
    run_instr(32'h100, 1, 1, 0, 0, 16'h0003, 26'h0, 32'h0, 0, 0);
    check("br_fwd", 64'(next_pc), 64'h110);

    // Wait states in IF and MEM.
    run_instr(32'h200, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 3, 2);
    check("wait_cycles", 64'(cyc),   64'd10);
    check("wait_ir_cnt", 64'(irc),   64'd1);
    check("wait_ir_at",  64'(ir_at), 64'd4);
    check("wait_pc_cnt", 64'(pcc),   64'd1);
    check("wait_pc_at",  64'(pc_at), 64'd10);

    // Address wrap; eighth instruction also wraps the 3-bit counter.
    run_instr(32'hFFFF_FFFC, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
    check("pc_wrap",       64'(next_pc),   64'h0);
    check("retired_8",     64'(retired),   64'd8);
    check("retired_s_wrap", 64'(retired_s), 64'd0);

    // Reset in the middle of EX.
    run_instr(32'h0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h40, 0, 0);
    check("pre_rst_npc", 64'(next_pc), 64'h40);
    mem_ready = 1'b1; step();
    step();
    check("in_ex", 64'(phase), 64'h4);
    rst = 1'b0;
    #1;
    check("midrst_phase",   64'(phase),   64'h1);
    check("midrst_next_pc", 64'(next_pc), 64'h0);
    check("midrst_retired", 64'(retired), 64'h0);
    check("midrst_pc_we",   64'(pc_we),   64'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      run_instr($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                26'($urandom), $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
